// File: rtl/spi_flash_slave.sv
`timescale 1ns/1ps
// spi_flash_slave
// Makes the board look like a serial NOR flash on an external SPI bus (mode 0).
// The host's command and 24-bit address are decoded. Data bytes are fetched one
// at a time through the SDRAM logical read port and shifted out on MISO.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   spi_clk/cs_n/mosi   raw asynchronous pins from the SPI host
//   spi_miso/_oe        MISO data and its output enable (to a gpio pad)
//   rd_addr/rd_enable   SDRAM read request (byte address, one-cycle pulse)
//   rd_data/rd_ready    SDRAM read completion (data valid on the rd_ready pulse)
//   busy                SDRAM controller busy; no request is issued while high
//   cmd/cmd_strobe      last command byte, pulsed for one clk when it updates
//   addr/addr_strobe    last address, pulsed for one clk when it completes
//   underrun            sticky: a data byte was due before SDRAM returned it
//
// Read port handshake: rd_enable is a one-cycle request, raised only on a
// cycle after busy was seen low, and it is accepted without further
// acknowledgement. Exactly one request is in flight at a time. The matching
// rd_ready is a one-cycle pulse that carries rd_data. Any completion that
// arrives after chip select was released is dropped.
module spi_flash_slave #(
  parameter logic [23:0] JEDEC_ID = 24'hEF4018,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [24:0] rd_addr,
  output logic        rd_enable,
  input  logic [7:0]  rd_data,
  input  logic        rd_ready,
  input  logic        busy,
  output logic [7:0]  cmd,
  output logic        cmd_strobe,
  output logic [23:0] addr,
  output logic        addr_strobe,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_JEDEC, S_STAT, S_IGNORE
  } state_t;

  state_t state;

  // Two-flop synchronizers plus the previous synchronized SPI clock.
  logic [1:0]  clk_sync;
  logic [1:0]  cs_sync;
  logic [1:0]  mosi_sync;
  logic        sclk_d;

  logic [2:0]  bit_cnt;        // rising edges seen in the current byte
  logic [1:0]  byte_cnt;       // address bytes already received
  logic        dummy_flag;
  logic [22:0] rx_sh;
  logic [7:0]  tx_sh;
  logic [1:0]  id_idx;         // next JEDEC byte; 3 means "past the ID"

  logic [23:0] rd_ptr;         // address of the next byte to request
  logic        req_pend;
  logic        rd_outstanding;
  logic        buf_valid;
  logic [7:0]  buf_data;

  logic        sclk_s;
  logic        cs_s;
  logic        mosi_s;
  logic        sclk_rise;
  logic        sclk_fall;
  logic [23:0] rx_next;
  logic        byte_done;
  logic        data_avail;
  logic [7:0]  data_byte;
  logic [7:0]  jedec_byte;
  logic [7:0]  load_byte;
  logic        tx_active;

  always_comb begin
    sclk_s    = clk_sync[1];
    cs_s      = cs_sync[1];
    mosi_s    = mosi_sync[1];
    sclk_rise = sclk_s & ~sclk_d;
    sclk_fall = ~sclk_s & sclk_d;
    rx_next   = {rx_sh, mosi_s};
    byte_done = sclk_rise && (bit_cnt == 3'd7);
    // A completion landing on the boundary cycle is used directly.
    data_avail = buf_valid | (rd_outstanding & rd_ready);
    data_byte  = buf_valid ? buf_data : rd_data;
    case (id_idx)
      2'd0:    jedec_byte = JEDEC_ID[23:16];
      2'd1:    jedec_byte = JEDEC_ID[15:8];
      2'd2:    jedec_byte = JEDEC_ID[7:0];
      default: jedec_byte = 8'hFF;
    endcase
    case (state)
      S_DATA:  load_byte = data_avail ? data_byte : 8'hFF;
      S_JEDEC: load_byte = jedec_byte;
      S_STAT:  load_byte = STATUS;
      default: load_byte = 8'hFF;
    endcase
    tx_active = (state == S_DATA) || (state == S_JEDEC) || (state == S_STAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync       <= 2'b00;
      cs_sync        <= 2'b11;
      mosi_sync      <= 2'b00;
      sclk_d         <= 1'b0;
      state          <= S_IDLE;
      bit_cnt        <= 3'd0;
      byte_cnt       <= 2'd0;
      dummy_flag     <= 1'b0;
      rx_sh          <= 23'd0;
      tx_sh          <= 8'hFF;
      id_idx         <= 2'd0;
      rd_ptr         <= 24'd0;
      req_pend       <= 1'b0;
      rd_outstanding <= 1'b0;
      buf_valid      <= 1'b0;
      buf_data       <= 8'h00;
      spi_miso       <= 1'b1;
      spi_miso_oe    <= 1'b0;
      rd_addr        <= 25'd0;
      rd_enable      <= 1'b0;
      cmd            <= 8'h00;
      cmd_strobe     <= 1'b0;
      addr           <= 24'd0;
      addr_strobe    <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[0], spi_clk};
      cs_sync     <= {cs_sync[0], spi_cs_n};
      mosi_sync   <= {mosi_sync[0], spi_mosi};
      sclk_d      <= sclk_s;
      rd_enable   <= 1'b0;
      cmd_strobe  <= 1'b0;
      addr_strobe <= 1'b0;

      if (cs_s) begin
        // Deselected: everything in flight is abandoned, CS beats any edge.
        state          <= S_IDLE;
        spi_miso_oe    <= 1'b0;
        spi_miso       <= 1'b1;
        bit_cnt        <= 3'd0;
        byte_cnt       <= 2'd0;
        dummy_flag     <= 1'b0;
        id_idx         <= 2'd0;
        req_pend       <= 1'b0;
        rd_outstanding <= 1'b0;
        buf_valid      <= 1'b0;
      end else begin
        if (rd_outstanding && rd_ready) begin
          buf_data       <= rd_data;
          buf_valid      <= 1'b1;
          rd_outstanding <= 1'b0;
        end

        if (req_pend && !busy) begin
          rd_enable      <= 1'b1;
          rd_addr        <= {1'b0, rd_ptr};
          req_pend       <= 1'b0;
          rd_outstanding <= 1'b1;
        end

        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx_sh   <= rx_next[22:0];
        end

        case (state)
          S_IDLE: state <= S_CMD;
          S_CMD: begin
            if (byte_done) begin
              cmd        <= rx_next[7:0];
              cmd_strobe <= 1'b1;
              byte_cnt   <= 2'd0;
              id_idx     <= 2'd0;
              case (rx_next[7:0])
                8'h03: begin state <= S_ADDR;  dummy_flag <= 1'b0; end
                8'h0B: begin state <= S_ADDR;  dummy_flag <= 1'b1; end
                8'h9F: begin state <= S_JEDEC; spi_miso_oe <= 1'b1; end
                8'h05: begin state <= S_STAT;  spi_miso_oe <= 1'b1; end
                default: state <= S_IGNORE;
              endcase
            end
          end
          S_ADDR: begin
            if (byte_done) begin
              if (byte_cnt == 2'd2) begin
                addr        <= rx_next;
                addr_strobe <= 1'b1;
                rd_ptr      <= rx_next;
                req_pend    <= 1'b1;
                if (dummy_flag) begin
                  state <= S_DUMMY;
                end else begin
                  state       <= S_DATA;
                  spi_miso_oe <= 1'b1;
                end
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
              end
            end
          end
          S_DUMMY: begin
            if (byte_done) begin
              state       <= S_DATA;
              spi_miso_oe <= 1'b1;
            end
          end
          default: ;
        endcase

        // Falling edge with bit_cnt==0 is the byte boundary that drives bit 7.
        if (sclk_fall && tx_active) begin
          if (bit_cnt == 3'd0) begin
            spi_miso <= load_byte[7];
            tx_sh    <= {load_byte[6:0], 1'b1};
            if (state == S_JEDEC && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            if (state == S_DATA) begin
              if (data_avail) begin
                buf_valid <= 1'b0;
                rd_ptr    <= rd_ptr + 24'd1;
                req_pend  <= 1'b1;
              end else begin
                // The pointer holds, so a read still in flight fills the
                // buffer for the next boundary.
                underrun <= 1'b1;
              end
            end
          end else begin
            spi_miso <= tx_sh[7];
            tx_sh    <= {tx_sh[6:0], 1'b1};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_slave.sv
`timescale 1ns/1ps
// Testbench for spi_flash_slave: an SPI host driver, an SDRAM read responder,
// and monitors that pop expected MISO bytes, read addresses, commands and
// addresses from queues filled by the stimulus tasks.
module tb_spi_flash_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [24:0] rd_addr;
  logic        rd_enable;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_ready = 1'b0;
  logic        busy = 1'b0;
  logic [7:0]  cmd;
  logic        cmd_strobe;
  logic [23:0] addr;
  logic        addr_strobe;
  logic        underrun;

  int checks = 0;
  int failures = 0;
  int half_clk = 16;
  int lat = 6;

  logic [7:0]  exp_q[$];
  logic [24:0] exp_rd_q[$];
  logic [7:0]  exp_cmd_q[$];
  logic [23:0] exp_addr_q[$];
  logic [7:0]  mem [logic [23:0]];

  spi_flash_slave dut (
    .clk         (clk),
    .reset       (reset),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .rd_addr     (rd_addr),
    .rd_enable   (rd_enable),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .busy        (busy),
    .cmd         (cmd),
    .cmd_strobe  (cmd_strobe),
    .addr        (addr),
    .addr_strobe (addr_strobe),
    .underrun    (underrun)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    checks++;
    failures++;
    $display("FAIL %s got=%h required=none", name, got);
  endtask

  // ---------------- SDRAM responder ----------------
  initial begin
    logic [23:0] a;
    forever begin
      @(negedge clk);
      if (rd_enable === 1'b1) begin
        a = rd_addr[23:0];
        repeat (lat - 1) @(negedge clk);
        rd_data  = mem_rd(a);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  logic [7:0] mon_byte = 8'h00;
  int         mon_bits = 0;

  // Host samples MISO on rising SCK; only driven (oe=1) bits form bytes.
  always @(posedge spi_clk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      mon_bits = 0;
    end else if (spi_miso_oe === 1'b1) begin
      mon_byte = {mon_byte[6:0], spi_miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_q.size() == 0) unexpected("miso_byte_unexpected", 32'(mon_byte));
        else check("miso_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
      end
    end
  end

  logic cmd_stb_prev = 1'b0;
  logic addr_stb_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rd_enable) begin
        if (exp_rd_q.size() == 0) unexpected("rd_enable_unexpected", 32'(rd_addr));
        else check("rd_addr", 32'(rd_addr), 32'(exp_rd_q.pop_front()));
      end
      if (cmd_strobe && !cmd_stb_prev) begin
        if (exp_cmd_q.size() == 0) unexpected("cmd_strobe_unexpected", 32'(cmd));
        else check("cmd_value", 32'(cmd), 32'(exp_cmd_q.pop_front()));
      end
      if (cmd_stb_prev) check("cmd_strobe_width", 32'(cmd_strobe), 32'(0));
      if (addr_strobe && !addr_stb_prev) begin
        if (exp_addr_q.size() == 0) unexpected("addr_strobe_unexpected", 32'(addr));
        else check("addr_value", 32'(addr), 32'(exp_addr_q.pop_front()));
      end
      if (addr_stb_prev) check("addr_strobe_width", 32'(addr_strobe), 32'(0));
      cmd_stb_prev  = cmd_strobe;
      addr_stb_prev = addr_strobe;
    end
  end

  // ---------------- SPI host driver ----------------
  task automatic spi_bit(input logic b);
    spi_mosi = b;
    repeat (half_clk) @(negedge clk);
    spi_clk = 1'b1;
    repeat (half_clk) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (half_clk) @(negedge clk);
  endtask

  task automatic cs_high();
    int gap;
    gap = lat + 40;
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("oe_after_cs", 32'(spi_miso_oe), 32'(0));
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- transactions with reference model ----------------
  // Read model: byte i comes from address a+i (24-bit wrap). A request is
  // made at address completion and after each byte is loaded. With n full
  // data bytes there are n+1 boundaries (the last one on the closing SCK
  // fall), so requests cover a .. a+n+1. Starved reads return 0xFF and
  // issue no requests.
  task automatic do_read(input logic [7:0] c, input logic [23:0] a, input int n,
                         input int extra_bits, input bit starve);
    logic [23:0] ai;
    exp_cmd_q.push_back(c);
    exp_addr_q.push_back(a);
    for (int i = 0; i < n; i++) begin
      ai = a + 24'(i);
      exp_q.push_back(starve ? 8'hFF : mem_rd(ai));
    end
    if (!starve) begin
      for (int i = 0; i < n + 2; i++) begin
        ai = a + 24'(i);
        exp_rd_q.push_back({1'b0, ai});
      end
    end
    cs_low();
    send_byte(c);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    if (c == 8'h0B) send_byte(8'($urandom));
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    for (int i = 0; i < extra_bits; i++) spi_bit(1'($urandom));
    cs_high();
  endtask

  task automatic do_jedec(input int n);
    logic [7:0] id_b [3];
    id_b = '{8'hEF, 8'h40, 8'h18};
    exp_cmd_q.push_back(8'h9F);
    for (int i = 0; i < n; i++) exp_q.push_back(i < 3 ? id_b[i] : 8'hFF);
    cs_low();
    send_byte(8'h9F);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    cs_high();
  endtask

  task automatic do_stat(input int n);
    exp_cmd_q.push_back(8'h05);
    for (int i = 0; i < n; i++) exp_q.push_back(8'h00);
    cs_low();
    send_byte(8'h05);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    cs_high();
  endtask

  task automatic do_other(input logic [7:0] c, input int n);
    exp_cmd_q.push_back(c);
    cs_low();
    send_byte(c);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    cs_high();
  endtask

  task automatic abort_addr();
    exp_cmd_q.push_back(8'h03);
    cs_low();
    send_byte(8'h03);
    for (int i = 0; i < 12; i++) spi_bit(1'($urandom));
    cs_high();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  c;
    logic [23:0] a;
    int          kind;
    int          n;

    mem[24'h000100] = 8'hA5;
    mem[24'h000101] = 8'h3C;
    mem[24'h123458] = 8'h11;
    mem[24'h00ABC0] = 8'h22;

    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'(1));
    check("rst_oe", 32'(spi_miso_oe), 32'(0));
    check("rst_rd_enable", 32'(rd_enable), 32'(0));
    check("rst_rd_addr", 32'(rd_addr), 32'(0));
    check("rst_cmd", 32'(cmd), 32'(0));
    check("rst_cmd_strobe", 32'(cmd_strobe), 32'(0));
    check("rst_addr", 32'(addr), 32'(0));
    check("rst_addr_strobe", 32'(addr_strobe), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Plain read at 0x100, SDRAM latency 6.
    half_clk = 16; lat = 6;
    do_read(8'h03, 24'h000100, 2, 0, 1'b0);
    check("addr_after_read", 32'(addr), 32'h000100);

    // Fast read across the 24-bit wrap.
    do_read(8'h0B, 24'hFFFFFF, 2, 0, 1'b0);
    check("underrun_clear", 32'(underrun), 32'(0));

    do_jedec(4);
    check("cmd_jedec", 32'(cmd), 32'h9F);

    do_other(8'h06, 2);
    check("cmd_unknown", 32'(cmd), 32'h06);

    // Aborts: mid-address, then mid-data with a slow read still in flight.
    abort_addr();
    lat = 80;
    do_read(8'h0B, 24'h123456, 1, 1, 1'b0);
    lat = 6;
    do_read(8'h03, 24'h00ABC0, 2, 0, 1'b0);

    // Randomized mix.
    for (int t = 0; t < 8; t++) begin
      half_clk = $urandom_range(12, 16);
      lat      = $urandom_range(2, 8);
      kind     = $urandom_range(0, 4);
      n        = $urandom_range(1, 3);
      a        = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : 24'($urandom);
      case (kind)
        0: do_read(8'h03, a, n, 0, 1'b0);
        1: do_read(8'h0B, a, n, 0, 1'b0);
        2: do_jedec(n + 2);
        3: do_stat(n);
        default: begin
          do c = 8'($urandom); while (c inside {8'h03, 8'h0B, 8'h9F, 8'h05});
          do_other(c, n);
        end
      endcase
    end

    // Starved read: SDRAM held busy.
    half_clk = 16; lat = 200; busy = 1'b1;
    do_read(8'h03, 24'h000200, 2, 0, 1'b1);
    check("underrun_set", 32'(underrun), 32'(1));
    busy = 1'b0; lat = 6;
    do_read(8'h03, 24'h000100, 2, 0, 1'b0);
    check("underrun_sticky", 32'(underrun), 32'(1));

    repeat (300) @(negedge clk);
    check("miso_queue_drained", 32'(exp_q.size()), 32'(0));
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'(0));
    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'(0));
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
